controle_processador: RTL and testbench
=======================================

Name: controle_processador

Overview:
- Control unit for the 16-bit processor datapath.
- Sequences each instruction through timesteps T0..T3. It drives the bus multiplexer selects (register select, result-register select, immediate select), the register load enables, the IR load, the A/G load enables and the ALU operation.
- Sits between the instruction source (run input) and the datapath. It reads the IR contents back to decode.

Parameters:
- OP_W, 3, opcode field width (IR[15:13]).
- REG_W, 3, register index width; 8 general registers R0..R7.

Ports:
- clk  in  1  system clock, rising-edge.
- resetn  in  1  synchronous, active-low reset.
- run  in  1  start request; sampled in T0 only.
- ir  in  16  current IR contents: opcode IR[15:13], rx IR[12:10], ry IR[9:7], immediate IR[9:0].
- ir_in  out  1  IR load enable.
- r_in  out  8  one-hot general-register load enables.
- a_in  out  1  ALU operand register A load enable.
- g_in  out  1  ALU result register G load enable.
- alu_op  out  2  00 add, 01 sub, 10 and, 11 reserved.
- mux_select  out  3  register index driven onto the bus.
- mux_rsel  out  1  bus = G register.
- mux_imm_sel  out  1  bus = zero-extended immediate (priority over mux_rsel).
- done  out  1  one-cycle pulse on the final timestep of each instruction.
- busy  out  1  high in T1..T3.

Behaviour:
- Reset (resetn=0 at a clock edge): state <= T0. All outputs are combinational Moore/Mealy decodes of state, run and ir, so with state T0 and run=0 every output is 0.
- Reset mid-instruction: the instruction is abandoned. No further enables are issued, and done is not pulsed.
- Timestep state machine, encoded T0, T1, T2, T3:
  - T0: if run=1, assert ir_in and go to T1. Otherwise stay in T0 with no outputs.
  - run is ignored in T1..T3; the instruction always completes.
- Opcodes (ir[15:13]) and actions per timestep:
  - 000 mv rx,ry: T1 mux_select=ry, r_in[rx]=1, done=1, then T0.
  - 001 mvi rx,#imm: T1 mux_imm_sel=1, r_in[rx]=1, done=1, then T0.
  - 010 add / 011 sub / 100 and:
    - T1 mux_select=rx, a_in=1, go T2.
    - T2 mux_select=ry, alu_op = 00/01/10 respectively, g_in=1, go T3.
    - T3 mux_rsel=1, r_in[rx]=1, done=1, go T0.
  - 101..111 undefined: T1 done=1, no enables, then T0 (NOP).
- Selects:
  - mux_select defaults to 0 when unused.
  - mux_rsel and mux_imm_sel are never both 1.
  - r_in is either all zeros or exactly one-hot.
- Latency from run sampled in T0 to done: mv/mvi/NOP 1 cycle (done in T1); ALU ops 3 cycles (done in T3).
- Back-to-back issue: run held high restarts T0 in the cycle after done, with no bubble beyond T0.
- rx==ry for ALU ops is legal (e.g. add r2,r2 doubles r2).
- ir must stay stable T1..T3. The IR only loads in T0, so this is guaranteed.
- busy = (state != T0).

Decomposition:
- Shared package processador_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND.
  - ALU op codes ALU_ADD, ALU_SUB, ALU_AND.
  - the timestep state encoding T0..T3.
- Natural sub-module: decodificador_3x8, a combinational rx-to-one-hot decoder used for r_in.

Test Plan:
- Reset:
  - resetn=0 for 2 cycles while in T2 of an add -> state T0.
  - every output 0 with run=0.
  - no done pulse afterwards.
- mvi r3,#0x155:
  - ir=16'h2D55, run=1 -> T0 ir_in=1.
  - T1 mux_imm_sel=1, r_in=8'b0000_1000, done=1.
  - back to T0.
- mv r5,r1:
  - ir=16'h1480 -> T1 mux_select=1, r_in=8'b0010_0000, done=1.
- sub r2,r7:
  - ir=16'h6B80 -> T1 mux_select=2, a_in=1.
  - T2 mux_select=7, alu_op=01, g_in=1.
  - T3 mux_rsel=1, r_in=8'b0000_0100, done=1.
  - total 4 cycles including T0.
- Undefined opcode ir=16'hE000 -> T1 done=1, r_in/a_in/g_in all 0.
- run held high over mvi then add -> T0,T1,T0,T1,T2,T3 with done in cycles 2 and 6; run dropping in T2 does not stop the add.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared encodings for the processor control path: opcodes, ALU codes and timesteps.
package processador_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  function automatic logic is_alu(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

  function automatic logic [1:0] alu_code(input logic [2:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_3x8.sv
// Register index to one-hot load-enable decoder; all zeros when en is low.
module decodificador_3x8 #(
  parameter int N = 3
) (
  input  logic [N-1:0]      sel,
  input  logic              en,
  output logic [2**N-1:0]   y
);

  for (genvar i = 0; i < 2**N; i++) begin : g_dec
    assign y[i] = en & (sel == N'(i));
  end

endmodule

// File: rtl/controle_processador.sv
// Timestep sequencer for the 16-bit datapath: decodes IR per T0..T3 into bus selects and load enables.
module controle_processador
  import processador_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int REG_W = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [15:0]        ir,
  output logic               ir_in,
  output logic [2**REG_W-1:0] r_in,
  output logic               a_in,
  output logic               g_in,
  output logic [1:0]         alu_op,
  output logic [REG_W-1:0]   mux_select,
  output logic               mux_rsel,
  output logic               mux_imm_sel,
  output logic               done,
  output logic               busy
);

  tstep_t           state;
  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] rx, ry;
  logic             r_en;
  logic             unused_imm;

  assign op = ir[15 -: OP_W];
  assign rx = ir[12 -: REG_W];
  assign ry = ir[9 -: REG_W];
  // Low immediate bits only matter to the datapath bus, not to control.
  assign unused_imm = ^ir[6:0];

  always_ff @(posedge clk) begin
    if (!resetn) state <= T0;
    else begin
      case (state)
        T0:      state <= run ? T1 : T0;
        T1:      state <= is_alu(op) ? T2 : T0;
        T2:      state <= T3;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    ir_in       = 1'b0;
    r_en        = 1'b0;
    a_in        = 1'b0;
    g_in        = 1'b0;
    alu_op      = ALU_ADD;
    mux_select  = '0;
    mux_rsel    = 1'b0;
    mux_imm_sel = 1'b0;
    done        = 1'b0;
    case (state)
      T0: ir_in = run;
      T1: begin
        if (op == OP_MV) begin
          mux_select = ry;
          r_en       = 1'b1;
          done       = 1'b1;
        end else if (op == OP_MVI) begin
          mux_imm_sel = 1'b1;
          r_en        = 1'b1;
          done        = 1'b1;
        end else if (is_alu(op)) begin
          mux_select = rx;
          a_in       = 1'b1;
        end else begin
          done = 1'b1;
        end
      end
      T2: begin
        mux_select = ry;
        alu_op     = alu_code(op);
        g_in       = 1'b1;
      end
      default: begin
        mux_rsel = 1'b1;
        r_en     = 1'b1;
        done     = 1'b1;
      end
    endcase
  end

  assign busy = (state != T0);

  decodificador_3x8 #(.N(REG_W)) u_dec (
    .sel (rx),
    .en  (r_en),
    .y   (r_in)
  );

endmodule

// File: tb/tb_controle_processador.sv
// Randomized bench for controle_processador against a per-instruction expected-output queue.
module tb_controle_processador;

  logic        clk = 1'b0;
  logic        resetn, run;
  logic [15:0] ir;
  logic        ir_in, a_in, g_in, mux_rsel, mux_imm_sel, done, busy;
  logic [7:0]  r_in;
  logic [1:0]  alu_op;
  logic [2:0]  mux_select;

  typedef struct packed {
    logic       ir_in;
    logic [7:0] r_in;
    logic       a_in;
    logic       g_in;
    logic [1:0] alu_op;
    logic [2:0] msel;
    logic       rsel;
    logic       imm;
    logic       done;
    logic       busy;
  } rec_t;

  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  controle_processador dut (
    .clk         (clk),
    .resetn      (resetn),
    .run         (run),
    .ir          (ir),
    .ir_in       (ir_in),
    .r_in        (r_in),
    .a_in        (a_in),
    .g_in        (g_in),
    .alu_op      (alu_op),
    .mux_select  (mux_select),
    .mux_rsel    (mux_rsel),
    .mux_imm_sel (mux_imm_sel),
    .done        (done),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected outputs for every cycle after T0 of one instruction, straight from the opcode table.
  task automatic push_instr(input logic [15:0] iv);
    int   op, rx, ry;
    rec_t e;
    op = int'(iv[15:13]);
    rx = int'(iv[12:10]);
    ry = int'(iv[9:7]);
    e = '0; e.busy = 1'b1;
    if (op == 0) begin
      e.msel = 3'(ry); e.r_in = 8'(1 << rx); e.done = 1'b1; q.push_back(e);
    end else if (op == 1) begin
      e.imm = 1'b1; e.r_in = 8'(1 << rx); e.done = 1'b1; q.push_back(e);
    end else if (op >= 2 && op <= 4) begin
      e.msel = 3'(rx); e.a_in = 1'b1; q.push_back(e);
      e = '0; e.busy = 1'b1;
      e.msel = 3'(ry); e.alu_op = 2'(op - 2); e.g_in = 1'b1; q.push_back(e);
      e = '0; e.busy = 1'b1;
      e.rsel = 1'b1; e.r_in = 8'(1 << rx); e.done = 1'b1; q.push_back(e);
    end else begin
      e.done = 1'b1; q.push_back(e);
    end
  endtask

  task automatic step(input logic rn, input logic rq, input logic [15:0] iv);
    rec_t e, g;
    resetn = rn;
    run    = rq;
    if (q.size() == 0) begin
      ir = iv;
      e = '0;
      e.ir_in = rq;
      if (rq && rn) push_instr(iv);
    end else begin
      e = q.pop_front();
    end
    @(negedge clk);
    g = {ir_in, r_in, a_in, g_in, alu_op, mux_select, mux_rsel, mux_imm_sel, done, busy};
    chk($sformatf("cyc%0d ir=%h", cyc, ir), 32'(g), 32'(e));
    if (!rn) q.delete();
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; ir = '0;
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, 16'h0000);
    // mvi r3,#0x155
    step(1, 1, 16'h2D55); step(1, 0, 16'h0000); step(1, 0, 16'h0000);
    // mv r5,r1
    step(1, 1, 16'h1480); step(1, 0, 16'h0000);
    // sub r2,r7
    step(1, 1, 16'h6B80); step(1, 0, 16'h0); step(1, 0, 16'h0); step(1, 0, 16'h0);
    // undefined opcode
    step(1, 1, 16'hE000); step(1, 0, 16'h0);
    // back-to-back mvi then add r2,r2; run drops in T2
    step(1, 1, 16'h2D55); step(1, 1, 16'h0);
    step(1, 1, 16'h4900); step(1, 1, 16'h0); step(1, 0, 16'h0); step(1, 0, 16'h0);
    step(1, 0, 16'h0);
    // reset held two cycles while in T2 of an add
    step(1, 1, 16'h4900); step(1, 0, 16'h0);
    step(0, 0, 16'h0); step(0, 0, 16'h0);
    repeat (3) step(1, 0, 16'h0);
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step(($urandom % 40) != 0, ($urandom % 3) != 0, 16'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
